imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//   Instruction-memory responder: the memory end of the fetch interface.
//   Accepts a fetch request (pc) over valid/ready and returns the 32-bit
//   instruction after a fixed, parameterised latency.
//   Sits between the core's fetch stage and a word-addressed instruction
//   store, preloaded via a backdoor load port.
//   One outstanding request at a time.
// PARAMETERS
//   DEPTH_WORDS  1024          instruction words stored (power of 2)
//   BASE_ADDR    32'h80000000  byte address of word 0 (matches pc reset value)
//   LATENCY      2             cycles from request handshake to resp_valid; legal 1..7
// PORTS
//   clk        in   1   clock; all logic on rising edge
//   rst        in   1   synchronous, active-low reset
//   req_valid  in   1   fetch request valid
//   req_ready  out  1   responder can accept a request
//   req_addr   in   32  fetch byte address (pc)
//   resp_valid out  1   instruction response valid
//   resp_ready in   1   fetch stage accepts the response
//   resp_inst  out  32  instruction word
//   resp_err   out  1   request was misaligned or out of range
//   load_en    in   1   backdoor write enable
//   load_addr  in   32  backdoor byte address (same map as req_addr)
//   load_data  in   32  backdoor write data
// BEHAVIOUR
//   Reset (rst==0 at a clock edge):
//     - state=IDLE; req_ready=0 during reset, 1 from the first cycle after.
//     - resp_valid=0, resp_inst=0, resp_err=0, latency counter=0.
//     - Memory contents are NOT cleared.
//     - Reset mid-operation drops any in-flight request; no response is produced.
//   Address check: idx = (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned.
//     - Error if addr[1:0] != 0 or (addr - BASE_ADDR) >= 4*DEPTH_WORDS.
//     - Wrap-around below BASE_ADDR counts as out of range.
//   FSM IDLE -> WAIT -> RESP -> IDLE:
//     - IDLE: req_ready=1.
//       * On req_valid&&req_ready at edge t: mem[idx] (or the error value)
//         and the error flag are sampled into output regs; counter=LATENCY-1.
//       * Next state is WAIT, or RESP directly if LATENCY==1.
//     - WAIT: req_ready=0; counter decrements each cycle; at counter==1 go to RESP.
//       * resp_valid rises exactly LATENCY cycles after the handshake edge.
//     - RESP: resp_valid=1.
//       * resp_inst/resp_err held stable until resp_valid&&resp_ready.
//       * Then -> IDLE; req_ready=1 the following cycle.
//       * No back-to-back accept in the same cycle.
//   Backpressure: resp_ready may stay low indefinitely; the response is held, never dropped.
//   Load port:
//     - load_en writes mem[load idx] at the edge; silently ignored if the address is in error.
//     - Load to the same word as a same-cycle request handshake: the response
//       carries the OLD word; the new word is visible to later requests.
//     - Loads during WAIT/RESP never alter an in-flight response.
//   Error response: resp_err=1; resp_inst = error value (see CONFIGURATION).
// CONFIGURATION
//   IMEM_RESP_EBREAK_ON_ERR_EN
//     - defined:     error responses return resp_inst=32'h00100073 (ebreak) so
//                    the core traps/halts on a bad fetch.
//     - not defined: error responses return resp_inst=32'h00000000.
//     - resp_err is asserted identically in both cases.
// TESTING
//   1. LATENCY=2; load 0x80000000<-0x00500093; req 0x80000000 at t
//      -> resp_valid at t+2, inst=0x00500093, err=0.
//   2. resp_ready held 0 for 5 cycles in RESP
//      -> resp_valid/inst stable, req_ready=0; after handshake req_ready=1 next cycle.
//   3. req 0x80000002 and req 0x7FFFFFFC
//      -> err=1, inst=0 (macro off) / 0x00100073 (macro on).
//   4. req 0x80000000+4*DEPTH_WORDS (0x80001000 at default) -> err=1;
//      last word 0x80000FFC -> err=0.
//   5. Same-cycle load 0x80000004<-0xDEADBEEF and req 0x80000004 (old 0x00000013)
//      -> resp 0x00000013; a later req -> 0xDEADBEEF.
//   6. rst=0 during WAIT -> resp_valid never rises; after release req_ready=1
//      and the next request behaves as in scenario 1.

Source files
------------

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder returning fetched words after a fixed latency
// Optional feature macro: IMEM_RESP_EBREAK_ON_ERR_EN (error responses return ebreak instead of zero)
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

`ifdef IMEM_RESP_EBREAK_ON_ERR_EN
    localparam logic [31:0] ERR_INST = 32'h0010_0073;
`else
    localparam logic [31:0] ERR_INST = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;
    logic       accept;

    logic [31:0] mem [DEPTH_WORDS];

    // Offsets are taken modulo 2^32 so addresses below BASE_ADDR wrap high and fail the range check.
    logic [31:0]      req_off;
    logic [31:0]      load_off;
    logic             req_bad;
    logic             load_bad;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;

    // Address decode and error classification for both the fetch and backdoor ports.
    always_comb begin
        req_off  = req_addr - BASE_ADDR;
        load_off = load_addr - BASE_ADDR;
        req_bad  = (req_addr[1:0] != 2'b00) || (req_off >= SPAN);
        load_bad = (load_addr[1:0] != 2'b00) || (load_off >= SPAN);
        req_idx  = req_off[IDX_W+1:2];
        load_idx = load_off[IDX_W+1:2];
    end

    // Next-state, latency countdown and handshake outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst;
                if (req_valid && rst) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = (CNT_INIT == 3'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and response capture; the word is sampled at accept so later loads cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            resp_inst <= 32'h0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                resp_err  <= req_bad;
                resp_inst <= req_bad ? ERR_INST : mem[req_idx];
            end
        end
    end

    // Backdoor store; contents survive reset and bad addresses are dropped.
    always_ff @(posedge clk) begin
        if (load_en && !load_bad) begin
            mem[load_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed bench for imem_responder with a shadow-memory reference model
module tb_imem_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef IMEM_RESP_EBREAK_ON_ERR_EN
    localparam logic [31:0] ERRV  = 32'h0010_0073;
`else
    localparam logic [31:0] ERRV  = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;

    int checks = 0;
    int failures = 0;

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_inst (resp_inst),
        .resp_err  (resp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow store plus one pending-response record.
    logic [31:0] shadow [int unsigned];
    bit          init = 0;
    bit          busy = 0;
    int          edges = 0;
    int          hs_edge = 0;
    logic [31:0] m_inst = 32'h0;
    logic        m_err = 1'b0;
    bit          m_known = 0;

    function automatic bit addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
    endfunction

    always @(posedge clk) begin
        logic [31:0] off;
        if (!rst) begin
            init    = 1;
            busy    = 0;
            m_inst  = 32'h0;
            m_err   = 1'b0;
            m_known = 1;
        end else if (init) begin
            if (busy && (edges - hs_edge >= LAT)) begin
                if (resp_ready) busy = 0;
            end else if (!busy && req_valid) begin
                busy    = 1;
                hs_edge = edges;
                if (addr_bad(req_addr)) begin
                    m_err   = 1'b1;
                    m_inst  = ERRV;
                    m_known = 1;
                end else begin
                    off     = (req_addr - BASE) >> 2;
                    m_err   = 1'b0;
                    m_known = shadow.exists(off);
                    m_inst  = m_known ? shadow[off] : 32'h0;
                end
            end
        end
        if (load_en && !addr_bad(load_addr)) begin
            off = (load_addr - BASE) >> 2;
            shadow[off] = load_data;
        end
        edges++;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        bit e_valid;
        bit e_ready;
        if (init) begin
            e_valid = busy && (edges - hs_edge >= LAT);
            e_ready = (rst === 1'b1) && !busy;
            chk(resp_valid === e_valid, "model resp_valid", 32'(resp_valid), 32'(e_valid));
            chk(req_ready === e_ready, "model req_ready", 32'(req_ready), 32'(e_ready));
            chk(resp_err === m_err, "model resp_err", 32'(resp_err), 32'(m_err));
            if (m_known) chk(resp_inst === m_inst, "model resp_inst", resp_inst, m_inst);
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e,
                         input int hold, input bit ld, input logic [31:0] la, input logic [31:0] ld_d);
        int n;
        int lat;
        logic [31:0] held;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a;
        load_en = ld; load_addr = la; load_data = ld_d;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(n < 50, "req_ready timeout", 32'(n), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; load_en = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk(lat == LAT, "latency", 32'(lat), 32'(LAT));
        chk(resp_inst === exp_i, "literal inst", resp_inst, exp_i);
        chk(resp_err === exp_e, "literal err", 32'(resp_err), 32'(exp_e));
        held = resp_inst;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk(resp_valid === 1'b1, "held resp_valid", 32'(resp_valid), 32'd1);
            chk(resp_inst === held, "held resp_inst", resp_inst, held);
            chk(req_ready === 1'b0, "held req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk(req_ready === 1'b1, "ready after resp", 32'(req_ready), 32'd1);
        chk(resp_valid === 1'b0, "valid after resp", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk(req_ready === 1'b0, "ready in reset", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk(req_ready === 1'b1, "reset req_ready", 32'(req_ready), 32'd1);
        chk(resp_valid === 1'b0, "reset resp_valid", 32'(resp_valid), 32'd0);
        chk(resp_inst === 32'h0, "reset resp_inst", resp_inst, 32'h0);
        chk(resp_err === 1'b0, "reset resp_err", 32'(resp_err), 32'd0);

        // Basic fetch, then a backpressured fetch.
        load(32'h8000_0000, 32'h0050_0093);
        fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 0, 0, 32'h0, 32'h0);
        fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 5, 0, 32'h0, 32'h0);

        // Misaligned and below-base requests.
        fetch(32'h8000_0002, ERRV, 1'b1, 0, 0, 32'h0, 32'h0);
        fetch(32'h7FFF_FFFC, ERRV, 1'b1, 1, 0, 32'h0, 32'h0);

        // Range boundary.
        fetch(32'h8000_1000, ERRV, 1'b1, 0, 0, 32'h0, 32'h0);
        load(32'h8000_0FFC, 32'h1234_5678);
        fetch(32'h8000_0FFC, 32'h1234_5678, 1'b0, 0, 0, 32'h0, 32'h0);

        // A misaligned load aliasing word 0 must be dropped.
        load(32'h8000_0002, 32'h0BAD_0BAD);
        fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 0, 0, 32'h0, 32'h0);

        // Same-cycle load and fetch of one word.
        load(32'h8000_0004, 32'h0000_0013);
        fetch(32'h8000_0004, 32'h0000_0013, 1'b0, 0, 1, 32'h8000_0004, 32'hDEAD_BEEF);
        fetch(32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 0, 0, 32'h0, 32'h0);

        // Load during WAIT/RESP leaves the in-flight word alone.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        load_en = 1'b1; load_addr = 32'h8000_0004; load_data = 32'hCAFE_F00D;
        @(negedge clk);
        load_en = 1'b0;
        chk(resp_valid === 1'b1, "load-in-flight valid", 32'(resp_valid), 32'd1);
        chk(resp_inst === 32'hDEAD_BEEF, "load-in-flight inst", resp_inst, 32'hDEAD_BEEF);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        fetch(32'h8000_0004, 32'hCAFE_F00D, 1'b0, 0, 0, 32'h0, 32'h0);

        // Reset while the request is in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(resp_valid === 1'b0, "no resp after reset", 32'(resp_valid), 32'd0);
            chk(req_ready === 1'b1, "ready after reset", 32'(req_ready), 32'd1);
        end
        fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 0, 0, 32'h0, 32'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
